// File: rtl/node_injector_pkg.sv
// Packet format and mesh-size defaults shared by node_injector and its bench.
// Mesh/queue defaults may be overridden with X_NODES, Y_NODES, INPUT_QUEUE_DEPTH, CREATE_ANT_PERIOD.
`ifndef X_NODES
`define X_NODES 2
`endif
`ifndef Y_NODES
`define Y_NODES 2
`endif
`ifndef INPUT_QUEUE_DEPTH
`define INPUT_QUEUE_DEPTH 2
`endif
`ifndef CREATE_ANT_PERIOD
`define CREATE_ANT_PERIOD 10
`endif

package node_injector_pkg;

    localparam int unsigned X_NODES = `X_NODES;
    localparam int unsigned Y_NODES = `Y_NODES;
    localparam int unsigned XW      = (X_NODES > 1) ? $clog2(X_NODES) : 1;
    localparam int unsigned YW      = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;
    localparam int unsigned MEMW    = 4;

    typedef struct packed {
        logic            ant;
        logic            backward;
        logic [XW-1:0]   x_source;
        logic [YW-1:0]   y_source;
        logic [XW-1:0]   x_dest;
        logic [YW-1:0]   y_dest;
        logic [XW-1:0]   x_memory;
        logic [YW-1:0]   y_memory;
        logic [MEMW-1:0] num_memories;
    } packet_t;

endpackage

// File: rtl/node_injector.sv
// Traffic source for one mesh node: LFSR-driven data packets through a FIFO, plus
// periodic ant packets when NODE_INJECTOR_ANT_EN is defined.
module node_injector
    import node_injector_pkg::*;
#(
    parameter int unsigned X_LOC       = 0,
    parameter int unsigned Y_LOC       = 0,
    parameter int unsigned PACKET_RATE = 2,
    parameter int unsigned QUEUE_DEPTH = `INPUT_QUEUE_DEPTH * 8,
    parameter int unsigned ANT_PERIOD  = `CREATE_ANT_PERIOD,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    output packet_t     o_data,
    output logic        o_data_val,
    output logic [31:0] o_gen_count,
    output logic [31:0] o_inj_count,
    output logic [31:0] o_drop_count
);

    localparam int unsigned   AW     = $clog2(QUEUE_DEPTH);
    localparam logic [7:0]    RATE   = 8'(PACKET_RATE);
    localparam logic [XW-1:0] X_SELF = XW'(X_LOC);
    localparam logic [YW-1:0] Y_SELF = YW'(Y_LOC);

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("node_injector: QUEUE_DEPTH must be a power of two of at least 2");
    end
    if (ANT_PERIOD < 2) begin : g_bad_ant_period
        $error("node_injector: ANT_PERIOD must be at least 2");
    end
    if (PACKET_RATE > 100) begin : g_bad_rate
        $error("node_injector: PACKET_RATE must be 0..100");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("node_injector: LFSR_SEED must be nonzero");
    end

    logic [15:0] lfsr_q, lfsr_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    packet_t     mem_q [QUEUE_DEPTH];
    packet_t     mem_d [QUEUE_DEPTH];
    packet_t     hold_q, hold_d;
    logic [31:0] gen_cnt_q, gen_cnt_d;
    logic [31:0] inj_cnt_q, inj_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

`ifdef NODE_INJECTOR_ANT_EN
    localparam int unsigned CW = $clog2(ANT_PERIOD);
    logic [CW-1:0] ant_cnt_q, ant_cnt_d;
    logic          ant_pending_q, ant_pending_d;
    packet_t       ant_pkt_q, ant_pkt_d;
`endif

    logic [7:0] rand_mod;
    logic [8:0] rate_diff;
    logic       gen_evt;
    logic       self_dest;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic       xfer;
    logic       ant_sel;
    packet_t    base_pkt;
    packet_t    new_pkt;
    packet_t    sel_pkt;

    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // Borrow out of (mod - rate) means mod < rate; avoids a constant compare at rate 0.
        rand_mod  = 8'(lfsr_q % 16'd100);
        rate_diff = {1'b0, rand_mod} - {1'b0, RATE};
        gen_evt   = rate_diff[8];

        base_pkt          = '0;
        base_pkt.x_source = X_SELF;
        base_pkt.y_source = Y_SELF;
        new_pkt           = base_pkt;
        new_pkt.x_dest    = XW'(lfsr_q[7:0] % 8'(X_NODES));
        new_pkt.y_dest    = YW'(lfsr_q[15:8] % 8'(Y_NODES));
        self_dest         = (new_pkt.x_dest == X_SELF) && (new_pkt.y_dest == Y_SELF);

        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        // Fullness is judged before this cycle's pop, so a same-cycle pop never rescues a push.
        push       = gen_evt && !self_dest && !fifo_full;

        ant_sel = 1'b0;
        sel_pkt = mem_q[rptr_q[AW-1:0]];
`ifdef NODE_INJECTOR_ANT_EN
        ant_sel = ant_pending_q;
        if (ant_pending_q) begin
            sel_pkt = ant_pkt_q;
        end
`endif
        xfer = !reset && i_en && (ant_sel || !fifo_empty);
        pop  = xfer && !ant_sel;

        wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        mem_d  = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = new_pkt;
        end

        hold_d     = xfer ? sel_pkt : hold_q;
        o_data     = xfer ? sel_pkt : hold_q;
        o_data_val = xfer;

        gen_cnt_d  = push ? gen_cnt_q + 32'd1 : gen_cnt_q;
        inj_cnt_d  = xfer ? inj_cnt_q + 32'd1 : inj_cnt_q;
        drop_cnt_d = (gen_evt && !self_dest && fifo_full) ? drop_cnt_q + 32'd1 : drop_cnt_q;

`ifdef NODE_INJECTOR_ANT_EN
        ant_cnt_d     = (ant_cnt_q == CW'(ANT_PERIOD - 1)) ? '0 : ant_cnt_q + CW'(1);
        ant_pending_d = ant_pending_q;
        ant_pkt_d     = ant_pkt_q;
        // A period boundary that lands while an ant is still waiting is ignored.
        if (xfer && ant_pending_q) begin
            ant_pending_d = 1'b0;
        end else if (ant_cnt_q == '0 && !ant_pending_q && !self_dest) begin
            ant_pending_d = 1'b1;
            ant_pkt_d     = new_pkt;
            ant_pkt_d.ant = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q     <= LFSR_SEED;
            wptr_q     <= '0;
            rptr_q     <= '0;
            hold_q     <= base_pkt;
            gen_cnt_q  <= '0;
            inj_cnt_q  <= '0;
            drop_cnt_q <= '0;
`ifdef NODE_INJECTOR_ANT_EN
            ant_cnt_q     <= '0;
            ant_pending_q <= 1'b0;
            ant_pkt_q     <= base_pkt;
`endif
        end else begin
            lfsr_q     <= lfsr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            hold_q     <= hold_d;
            gen_cnt_q  <= gen_cnt_d;
            inj_cnt_q  <= inj_cnt_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef NODE_INJECTOR_ANT_EN
            ant_cnt_q     <= ant_cnt_d;
            ant_pending_q <= ant_pending_d;
            ant_pkt_q     <= ant_pkt_d;
`endif
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_gen_count  = gen_cnt_q;
    assign o_inj_count  = inj_cnt_q;
    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_node_injector.sv
// Self-checking bench for node_injector: idle, saturation, steady-drain, self-destination
// and a scoreboarded random run with a mid-run reset.
module tb_node_injector;
    import node_injector_pkg::*;

    localparam int C_X = 1, C_Y = 0, C_RATE = 50, C_DEPTH = 8, C_ANT = 10;
    localparam logic [15:0] C_SEED = 16'h1234;
    localparam logic [15:0] DEF_SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_c;
    logic en_a, en_b, en_c, en_d;
    packet_t o_data_a, o_data_b, o_data_c, o_data_d;
    logic val_a, val_b, val_c, val_d;
    logic [31:0] gen_a, inj_a, drop_a, gen_b, inj_b, drop_b;
    logic [31:0] gen_c, inj_c, drop_c, gen_d, inj_d, drop_d;

    node_injector #(.PACKET_RATE(0)) u_idle (
        .clk(clk), .reset(rst), .i_en(en_a), .o_data(o_data_a), .o_data_val(val_a),
        .o_gen_count(gen_a), .o_inj_count(inj_a), .o_drop_count(drop_a));

    node_injector #(.X_LOC(1), .Y_LOC(1), .PACKET_RATE(100), .QUEUE_DEPTH(8)) u_full (
        .clk(clk), .reset(rst), .i_en(en_b), .o_data(o_data_b), .o_data_val(val_b),
        .o_gen_count(gen_b), .o_inj_count(inj_b), .o_drop_count(drop_b));

    node_injector #(.X_LOC(C_X), .Y_LOC(C_Y), .PACKET_RATE(C_RATE), .QUEUE_DEPTH(C_DEPTH),
                    .ANT_PERIOD(C_ANT), .LFSR_SEED(C_SEED)) u_main (
        .clk(clk), .reset(rst_c), .i_en(en_c), .o_data(o_data_c), .o_data_val(val_c),
        .o_gen_count(gen_c), .o_inj_count(inj_c), .o_drop_count(drop_c));

    node_injector #(.X_LOC(0), .Y_LOC(0), .PACKET_RATE(100)) u_drain (
        .clk(clk), .reset(rst), .i_en(en_d), .o_data(o_data_d), .o_data_val(val_d),
        .o_gen_count(gen_d), .o_inj_count(inj_d), .o_drop_count(drop_d));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic is_gen(input logic [15:0] l, input int rate);
        return (int'(l) % 100) < rate;
    endfunction

    function automatic packet_t reset_pkt(input int xs, input int ys);
        packet_t p = '0;
        p.x_source = XW'(xs);
        p.y_source = YW'(ys);
        return p;
    endfunction

    function automatic packet_t make_pkt(input logic [15:0] l, input int xs, input int ys);
        packet_t p = reset_pkt(xs, ys);
        p.x_dest = XW'(int'(l[7:0]) % int'(X_NODES));
        p.y_dest = YW'(int'(l[15:8]) % int'(Y_NODES));
        return p;
    endfunction

    function automatic logic not_self(input logic [15:0] l, input int xs, input int ys);
        packet_t p = make_pkt(l, xs, ys);
        return !(p.x_dest == XW'(xs) && p.y_dest == YW'(ys));
    endfunction

    // Scoreboard state for u_main
    packet_t     m_q[$];
    packet_t     m_hold, m_ant;
    logic        m_pend;
    int          m_cnt;
    logic [15:0] m_lfsr;
    logic [31:0] m_gen, m_inj, m_drop;
    logic        done_c = 1'b0;

    task automatic c_reset_model();
        m_q.delete();
        m_hold = reset_pkt(C_X, C_Y);
        m_ant  = '0;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_lfsr = C_SEED;
        m_gen  = '0;
        m_inj  = '0;
        m_drop = '0;
    endtask

    task automatic c_cycle(input logic r, input logic en);
        logic    exp_val, pend0, ns;
        int      sz0;
        packet_t sel, np;
        @(negedge clk);
        rst_c = r;
        en_c  = en;
        #1;
        exp_val = !r && en && (m_pend || m_q.size() != 0);
        check("c_val", 64'(val_c), 64'(exp_val));
        if (r) begin
            c_reset_model();
            return;
        end
        sel = m_hold;
        if (exp_val) sel = m_pend ? m_ant : m_q[0];
        check("c_data", 64'(o_data_c), 64'(sel));
        check("c_gen", 64'(gen_c), 64'(m_gen));
        check("c_inj", 64'(inj_c), 64'(m_inj));
        check("c_drop", 64'(drop_c), 64'(m_drop));
        pend0 = m_pend;
        sz0   = m_q.size();
        if (exp_val) begin
            m_hold = sel;
            m_inj++;
            if (m_pend) m_pend = 1'b0;
            else void'(m_q.pop_front());
        end
        np = make_pkt(m_lfsr, C_X, C_Y);
        ns = not_self(m_lfsr, C_X, C_Y);
        if (is_gen(m_lfsr, C_RATE) && ns) begin
            if (sz0 >= C_DEPTH) m_drop++;
            else begin
                m_q.push_back(np);
                m_gen++;
            end
        end
`ifdef NODE_INJECTOR_ANT_EN
        if (!pend0 && m_cnt == 0 && ns) begin
            m_pend    = 1'b1;
            m_ant     = np;
            m_ant.ant = 1'b1;
        end
        m_cnt = (m_cnt == C_ANT - 1) ? 0 : m_cnt + 1;
`else
        if (pend0) m_pend = 1'b1;
`endif
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    initial begin : c_thread
        rst_c = 1'b1;
        en_c  = 1'b0;
        c_reset_model();
        c_cycle(1'b1, 1'b0);
        c_cycle(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) c_cycle(1'b0, 1'($urandom_range(3, 0) != 0));
        for (int i = 0; i < 60 && m_q.size() < 5; i++) c_cycle(1'b0, 1'b0);
        c_cycle(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) c_cycle(1'b0, 1'($urandom_range(3, 0) != 0));
        done_c = 1'b1;
    end

    initial begin : main_thread
        logic [15:0] lb, ld;
        int          b_ns, d_ns, d_self, ants, diff, lim;
        logic        a_seen;
        rst  = 1'b1;
        en_a = 1'b1;
        en_b = 1'b0;
        en_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_val_a", 64'(val_a), 64'd0);
        check("rst_val_d", 64'(val_d), 64'd0);
        check("rst_gen_b", 64'(gen_b), 64'd0);
        check("rst_drop_b", 64'(drop_b), 64'd0);
        check("rst_inj_d", 64'(inj_d), 64'd0);
        check("rst_data_b", 64'(o_data_b), 64'(reset_pkt(1, 1)));
        @(negedge clk);
        rst = 1'b0;

        lb = DEF_SEED;
        ld = DEF_SEED;
        b_ns = 0; d_ns = 0; d_self = 0; ants = 0;
        a_seen = 1'b0;
`ifdef NODE_INJECTOR_ANT_EN
        lim = 2;
`else
        lim = 1;
`endif
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            #1;
            if (i <= 20) b_ns += int'(not_self(lb, 1, 1));
            lb = lfsr_next(lb);
            d_ns += int'(not_self(ld, 0, 0));
            ld = lfsr_next(ld);
            a_seen = a_seen | val_a;
            if (i == 20) begin
                check("b_gen", 64'(gen_b), 64'((b_ns >= 8) ? 8 : b_ns));
                check("b_drop", 64'(drop_b), 64'((b_ns >= 8) ? b_ns - 8 : 0));
                check("b_val", 64'(val_b), 64'd0);
            end
            if (i == 1000) begin
`ifndef NODE_INJECTOR_ANT_EN
                check("a_val", 64'(a_seen), 64'd0);
                check("a_inj", 64'(inj_a), 64'd0);
`endif
                check("a_gen", 64'(gen_a), 64'd0);
                check("a_drop", 64'(drop_a), 64'd0);
            end
            diff = int'(gen_d) - int'(inj_d) + ants;
            if (i % 50 == 0) check("d_track", 64'(diff >= 0 && diff <= lim), 64'd1);
            if (val_d && o_data_d.ant) ants++;
            if (val_d && o_data_d.x_dest == '0 && o_data_d.y_dest == '0) d_self++;
        end
        check("d_gen", 64'(gen_d), 64'(d_ns));
        check("d_drop", 64'(drop_d), 64'd0);
        check("d_self", 64'(d_self), 64'd0);
        check("d_inj_active", 64'(inj_d > 32'd1000), 64'd1);
        wait (done_c);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/node_injector.md
NODE_INJECTOR -- requirements
Module: node_injector

Interface
REQ-001 SHALL have parameter X_LOC, default 0: x coordinate of the attached node, loaded into x_source.
REQ-002 SHALL have parameter Y_LOC, default 0: y coordinate of the attached node, loaded into y_source.
REQ-003 SHALL have parameter PACKET_RATE, default 2: offered load in percent, legal range 0..100.
REQ-004 SHALL have parameter QUEUE_DEPTH, default `INPUT_QUEUE_DEPTH*8: data-packet FIFO entries, a power of two, at least 2.
REQ-005 SHALL have parameter ANT_PERIOD, default `CREATE_ANT_PERIOD: cycles between ant injections, at least 2.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero 16-bit LFSR seed.
REQ-007 SHALL have port clk, input, 1 bit: single clock, with all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-009 SHALL have port i_en, input, 1 bit: network o_en, meaning the network accepts a packet this cycle.
REQ-010 SHALL have port o_data, output, packet_t: packet presented to network i_data.
REQ-011 SHALL have port o_data_val, output, 1 bit: valid, driven to network i_data_val.
REQ-012 SHALL have port o_gen_count, output, 32 bits: data packets enqueued.
REQ-013 SHALL have port o_inj_count, output, 32 bits: packets (data and ant) transferred to the network.
REQ-014 SHALL have port o_drop_count, output, 32 bits: generated data packets lost to a full FIFO.

Function
REQ-015 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle out of reset.
REQ-016 SHALL form a generate event when (lfsr[15:0] mod 100) < PACKET_RATE; PACKET_RATE=0 never generates and PACKET_RATE=100 generates every cycle.
REQ-017 SHALL take the destination as x_dest = lfsr[7:0] mod `X_NODES and y_dest = lfsr[15:8] mod `Y_NODES, computed in the same cycle as the generate event.
REQ-018 SHALL suppress a generate event whose destination equals (X_LOC, Y_LOC), with no enqueue and no change to any counter.
REQ-019 SHALL build each enqueued data packet with x/y_source = X_LOC/Y_LOC, ant=0, backward=0, x_memory=0, y_memory=0 and num_memories=0.
REQ-020 SHALL implement the FIFO with registered storage, read/write pointers one bit wider than log2(QUEUE_DEPTH), and wrap-around at QUEUE_DEPTH.
REQ-021 SHALL, on a generate event with the FIFO full, drop the packet and increment o_drop_count; a pop in the same cycle does not free space for that packet.
REQ-022 SHALL drive o_data_val = i_en AND (ant_pending OR FIFO not empty), with the transfer completing in that same cycle.
REQ-023 SHALL give ant_pending priority over the FIFO head; o_data SHALL equal the selected packet whenever o_data_val is high and SHALL otherwise hold its last value.
REQ-024 SHALL, when FIFO pop and push coincide, perform both and leave occupancy unchanged; push to an empty FIFO SHALL be visible at the output the next cycle at the earliest (1-cycle minimum latency).
REQ-025 SHALL increment o_gen_count on each enqueue and o_inj_count on each transfer; all counters SHALL wrap modulo 2^32.

Reset
REQ-026 SHALL, while reset is high on a rising clk edge, set o_data_val=0, FIFO empty, counters=0, ant counter=0, ant_pending=0, LFSR=LFSR_SEED, and o_data=0 except x_source=X_LOC and y_source=Y_LOC.
REQ-027 SHALL discard any queued or pending packets on reset asserted mid-operation, and SHALL transfer nothing in the cycle reset is sampled high.

Configuration
REQ-028 SHALL, with NODE_INJECTOR_ANT_EN defined, count cycles modulo ANT_PERIOD and set ant_pending when the count reaches 0, building an ant packet (ant=1, random destination per REQ-017 and REQ-018, other fields per REQ-019) that is cleared on transfer; a new period boundary while ant_pending is set SHALL be ignored.
REQ-029 SHALL, without NODE_INJECTOR_ANT_EN, contain no ant counter or ant_pending logic, with ant tied to 0 on every output packet.

Verification
REQ-030 SHALL verify: PACKET_RATE=0, i_en=1 for 1000 cycles, ant disabled -> o_data_val never high and all counters 0.
REQ-031 SHALL verify: PACKET_RATE=100, QUEUE_DEPTH=8, i_en=0 for 20 cycles -> o_gen_count=8, o_drop_count = (non-self events) - 8, o_data_val=0.
REQ-032 SHALL verify: PACKET_RATE=100, i_en=1 steady -> o_inj_count tracks o_gen_count within 1, and o_drop_count=0.
REQ-033 SHALL verify: NODE_INJECTOR_ANT_EN defined, ANT_PERIOD=10, i_en=1 -> exactly one ant=1 transfer per 10 cycles, taking precedence over a non-empty FIFO.
REQ-034 SHALL verify: reset pulsed for 1 cycle with 5 packets queued -> the next cycle shows o_data_val=0 and counters=0, and the LFSR sequence restarts identically.
REQ-035 SHALL verify: X_LOC=Y_LOC=0 on a 2x2 mesh -> no packet with dest (0,0) is ever enqueued, checked over 5000 cycles.
